// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   XLEN_DEFAULT : default operand/result width
//   CNT_W        : width of the iteration counter
//   F3_*         : RV32M funct3 encodings
//   state_e      : control FSM encoding
//   rs1_signed / rs2_signed / is_div_op : funct3 decode helpers
package muldiv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned CNT_W        = 6;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Operand A is treated as two's complement for these ops.
    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // Operand B is treated as two's complement for these ops.
    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the shared {hi,lo} accumulator datapath (combinational).
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   opnd     : multiplicand (mul) or divisor (div) magnitude
//   hi, lo   : current accumulator; mul: {partial hi, remaining multiplier},
//              div: {partial remainder, dividend/quotient shifting}
//   hi_nxt_c, lo_nxt_c : accumulator after this step
module muldiv_iter_step
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] opnd,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] hi_nxt_c,
    output logic [XLEN-1:0] lo_nxt_c
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted  = {hi, lo[XLEN-1]};
        diff     = shifted - {1'b0, opnd};
        hi_nxt_c = add_sum[XLEN:1];
        lo_nxt_c = {add_sum[0], lo[XLEN-1:1]};
        if (is_div) begin
            // Top bit of diff is the borrow: set means the trial subtract failed.
            if (!diff[XLEN]) begin
                hi_nxt_c = diff[XLEN-1:0];
                lo_nxt_c = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt_c = shifted[XLEN-1:0];
                lo_nxt_c = {lo[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a one-cycle register-file write-back pulse.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, kill           : launch (sampled in IDLE) / abort in-flight op
//   funct3                : RV32M op select
//   rs1_data, rs2_data    : operands A / B
//   rd_addr_in            : destination captured at start
//   busy                  : high from accepted start until the DONE cycle ends
//   done                  : one-cycle completion pulse
//   RegWEn, rd_addr, rd_data : register-file write port
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle combinational
// multiplier for MUL* ops; divide stays iterative either way.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr_in,
    output logic            busy,
    output logic            done,
    output logic            RegWEn,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data
);

    localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              neg_q, neg_d;
    logic              busy_d, done_d, regwen_d;
    logic [4:0]        rd_addr_d;
    logic [XLEN-1:0]   rd_data_d;

    // Operand sign / magnitude decode on the incoming request.
    logic              a_neg, b_neg, res_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;

    always_comb begin
        a_neg    = rs1_signed(funct3) & rs1_data[XLEN-1];
        b_neg    = rs2_signed(funct3) & rs2_data[XLEN-1];
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;
        // Signed remainder follows the dividend sign only.
        res_neg  = (funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div_op(funct3) && (rs2_data == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (rs1_data == SIGNED_MIN) && (rs2_data == '1);
        if (div_zero) begin
            special_res = funct3[1] ? rs1_data : '1;
        end else begin
            special_res = funct3[1] ? '0 : SIGNED_MIN;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extend both operands to 2*XLEN; the truncated product is exact mod 2^(2*XLEN).
    logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]          fast_res;

    always_comb begin
        fast_a    = {{XLEN{a_neg}}, rs1_data};
        fast_b    = {{XLEN{b_neg}}, rs2_data};
        fast_prod = fast_a * fast_b;
        fast_res  = (funct3 == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // Iteration datapath.
    logic [XLEN-1:0] step_hi, step_lo;

    muldiv_iter_step #(.XLEN(XLEN)) u_step (
        .is_div   (op_q[2]),
        .opnd     (opnd_q),
        .hi       (hi_q),
        .lo       (lo_q),
        .hi_nxt_c (step_hi),
        .lo_nxt_c (step_lo)
    );

    // Sign fix-up and result selection from the finished accumulator.
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;

    always_comb begin
        prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_s  = neg_q ? -lo_q : lo_q;
        rem_s  = neg_q ? -hi_q : hi_q;
        case (op_q)
            F3_MUL:             fix_res = prod_s[XLEN-1:0];
            F3_DIV, F3_DIVU:    fix_res = quo_s;
            F3_REM, F3_REMU:    fix_res = rem_s;
            default:            fix_res = prod_s[2*XLEN-1:XLEN];
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_d     = neg_q;
        rd_addr_d = rd_addr;
        rd_data_d = rd_data;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        regwen_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    op_d      = funct3;
                    rd_addr_d = rd_addr_in;
                    neg_d     = res_neg;
                    cnt_d     = '0;
                    if (div_zero || div_ovf) begin
                        rd_data_d = special_res;
                        state_d   = S_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div_op(funct3)) begin
                        rd_data_d = fast_res;
                        state_d   = S_DONE;
                    end
`endif
                    else begin
                        // mul: opnd = multiplicand, lo = multiplier; div: opnd = divisor, lo = dividend.
                        hi_d    = '0;
                        opnd_d  = is_div_op(funct3) ? b_mag : a_mag;
                        lo_d    = is_div_op(funct3) ? a_mag : b_mag;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                rd_data_d = fix_res;
                state_d   = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (kill) begin
            state_d   = S_IDLE;
            rd_data_d = rd_data;
        end

        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        regwen_d = done_d && (rd_addr_d != 5'd0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            RegWEn  <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            busy    <= busy_d;
            done    <= done_d;
            RegWEn  <= regwen_d;
            rd_addr <= rd_addr_d;
            rd_data <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected write-backs,
// a monitor pops and compares on every done pulse (data, addr, enable, cycle).
module tb_muldiv_unit;

    localparam int LAT_ITER = 34;
    localparam int LAT_SPEC = 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = 34;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic [4:0]  rd_addr_in = 5'd0;
    logic        busy, done, RegWEn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        wen;
        int          cyc;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    muldiv_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .kill       (kill),
        .funct3     (funct3),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rd_addr_in (rd_addr_in),
        .busy       (busy),
        .done       (done),
        .RegWEn     (RegWEn),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got 0x%08h required 0x%08h", nm, id, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done === 1'b1) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: rd_data=0x%08h rd_addr=%0d, required no completion",
                             rd_data, rd_addr);
                end else begin
                    e = sb_q.pop_front();
                    chk("rd_data", e.id, rd_data, e.data);
                    chk("rd_addr", e.id, 32'(rd_addr), 32'(e.addr));
                    chk("RegWEn", e.id, 32'(RegWEn), 32'(e.wen));
                    chk("done_cycle", e.id, 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Drive a request for one cycle; called and returns at posedge+1.
    task automatic launch(input int id, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat, input bit expect_it);
        exp_t e;
        funct3     = f3;
        rs1_data   = a;
        rs2_data   = b;
        rd_addr_in = rd;
        start      = 1'b1;
        if (expect_it) begin
            e.data = exp;
            e.addr = rd;
            e.wen  = (rd != 5'd0);
            e.cyc  = cyc + lat;
            e.id   = id;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", id, 32'(busy), 32'd1);
    endtask

    // Wait (bounded) for the done pulse, then confirm busy drops the next cycle.
    task automatic finish_op(input int id);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout (vec %0d): got no done in 100 cycles, required a done pulse", id);
        end
        @(posedge clk);
        #1;
        chk("busy_after_done", id, 32'(busy), 32'd0);
        chk("done_one_cycle", id, 32'(done), 32'd0);
    endtask

    task automatic run_op(input int id, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat);
        launch(id, f3, a, b, rd, exp, lat, 1'b1);
        finish_op(id);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 0, 32'(busy), 32'd0);
        chk("reset_done", 0, 32'(done), 32'd0);
        chk("reset_regwen", 0, 32'(RegWEn), 32'd0);
        chk("reset_rd_addr", 0, 32'(rd_addr), 32'd0);
        chk("reset_rd_data", 0, rd_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors: id, funct3, rs1, rs2, rd, expected, latency.
        run_op( 1, 3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, LAT_MUL);
        run_op( 2, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, LAT_MUL);
        run_op( 3, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, LAT_MUL);
        run_op( 4, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, LAT_MUL);
        run_op( 5, 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd9,  32'h4000_0000, LAT_MUL);
        run_op( 6, 3'd4, 32'hFFFF_FFF9, 32'd2,        5'd10, 32'hFFFF_FFFD, LAT_ITER);
        run_op( 7, 3'd6, 32'hFFFF_FFF9, 32'd2,        5'd11, 32'hFFFF_FFFF, LAT_ITER);
        run_op( 8, 3'd5, 32'd100,      32'd7,        5'd12, 32'd14,        LAT_ITER);
        run_op( 9, 3'd7, 32'd100,      32'd7,        5'd13, 32'd2,         LAT_ITER);
        run_op(10, 3'd4, 32'd20,       32'hFFFF_FFFD, 5'd14, 32'hFFFF_FFFA, LAT_ITER);
        run_op(11, 3'd6, 32'd20,       32'hFFFF_FFFD, 5'd15, 32'd2,         LAT_ITER);
        run_op(12, 3'd5, 32'd5,        32'd0,        5'd16, 32'hFFFF_FFFF, LAT_SPEC);
        run_op(13, 3'd6, 32'd5,        32'd0,        5'd17, 32'd5,         LAT_SPEC);
        run_op(14, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, LAT_SPEC);
        run_op(15, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0,         LAT_SPEC);
        run_op(16, 3'd0, 32'd3,        32'd4,        5'd0,  32'd12,        LAT_MUL);
        run_op(17, 3'd0, 32'd6,        32'd7,        5'd20, 32'd42,        LAT_MUL);

        // Kill mid-CALC: no completion, busy drops immediately.
        d0 = done_cnt;
        launch(18, 3'd5, 32'd1000, 32'd3, 5'd21, 32'd0, LAT_ITER, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("busy_before_kill", 18, 32'(busy), 32'd1);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("busy_after_kill", 18, 32'(busy), 32'd0);
        chk("done_after_kill", 18, 32'(done), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("no_done_after_kill", 18, 32'(done_cnt), 32'(d0));

        // Start while busy is ignored: only the first op completes.
        d0 = done_cnt;
        launch(19, 3'd5, 32'd100, 32'd7, 5'd22, 32'd14, LAT_ITER, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        funct3   = 3'd7;
        rs1_data = 32'd9;
        rs2_data = 32'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_op(19);
        repeat (40) @(posedge clk);
        #1;
        chk("single_done", 19, 32'(done_cnt), 32'(d0 + 1));

        // Asynchronous reset mid-op clears outputs at once, no write-back later.
        d0 = done_cnt;
        launch(20, 3'd4, 32'd50, 32'd5, 5'd23, 32'd0, LAT_ITER, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 20, 32'(busy), 32'd0);
        chk("rst_done", 20, 32'(done), 32'd0);
        chk("rst_regwen", 20, 32'(RegWEn), 32'd0);
        chk("rst_rd_addr", 20, 32'(rd_addr), 32'd0);
        chk("rst_rd_data", 20, rd_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("no_done_after_reset", 20, 32'(done_cnt), 32'(d0));

        // Unit still works after reset.
        run_op(21, 3'd5, 32'd100, 32'd7, 5'd24, 32'd14, LAT_ITER);

        chk("scoreboard_empty", 0, 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
